prio_encoder_rr: RTL and testbench

- Parametrised N-input priority encoder; successor to the fixed 8-to-3 encoder.
- Adds registered output, valid/ready handshake, explicit no-request flag, one-hot grant, and a runtime-selectable round-robin mode.
- Sits between request sources (interrupt lines, channel requests) and any consumer that needs one winning index per transaction.

---
 rtl/enc_pkg.sv | 21 ++
 rtl/prio_find_first.sv | 33 +++
 rtl/prio_encoder_rr.sv | 73 +++++++
 tb/tb_prio_encoder_rr.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and helpers for the priority encoder
package enc_pkg;

  typedef enum logic {
    ENC_FIXED = 1'b0,
    ENC_RR    = 1'b1
  } enc_mode_e;

  localparam int ENC_MAX_N   = 64;
  localparam int ENC_MAX_N_W = 6;

  // Callers slice the low N bits; an index at or beyond n yields all zeros.
  function automatic logic [ENC_MAX_N-1:0] onehot_of(input int unsigned idx,
                                                     input int unsigned n);
    onehot_of = '0;
    if (idx < n && idx < ENC_MAX_N) begin
      onehot_of[idx[ENC_MAX_N_W-1:0]] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// rtl/prio_find_first.sv - first set bit at or after a start index, wrapping at N
module prio_find_first
  import enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // One spare bit so start + offset never overflows before the wrap at N.
  logic [IDX_W:0] w_pos;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = {1'b0, i_start} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(N)) begin
        w_pos = w_pos - (IDX_W+1)'(N);
      end
      if (!o_found && i_vec[w_pos[IDX_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered N-input priority encoder with fixed/round-robin modes
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  input  logic             mode_rr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_none
);

  logic                 r_valid;
  logic [IDX_W-1:0]     r_idx;
  logic [N-1:0]         r_onehot;
  logic                 r_none;
  logic [IDX_W-1:0]     r_ptr;

  enc_mode_e            w_mode;
  logic                 w_accept;
  logic [IDX_W-1:0]     w_start;
  logic                 w_found;
  logic [IDX_W-1:0]     w_idx;
  logic [ENC_MAX_N-1:0] w_onehot_full;

  assign w_mode        = enc_mode_e'(mode_rr);
  assign in_ready      = !r_valid || out_ready;
  assign w_accept      = in_valid && in_ready;
  assign w_start       = (w_mode == ENC_RR) ? r_ptr : '0;
  assign w_onehot_full = onehot_of(32'(w_idx), N);

  prio_find_first #(.N(N)) u_find (
    .i_vec   (in_req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_none   <= 1'b0;
      r_ptr    <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_none   <= !w_found;
      r_idx    <= w_found ? w_idx : '0;
      r_onehot <= w_found ? w_onehot_full[N-1:0] : '0;
      // An empty vector grants nobody, so the pointer stays put.
      if (w_mode == ENC_RR && w_found) begin
        r_ptr <= (w_idx == IDX_W'(N-1)) ? '0 : w_idx + 1'b1;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign out_none   = r_none;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - randomized and directed bench for prio_encoder_rr (N=8 and N=5)
module tb_prio_encoder_rr;

  logic       clk;
  logic       rst_n;

  logic       v8, rdy8, mode8, ov8, ordy8, none8;
  logic [7:0] req8, oh8;
  logic [2:0] idx8;

  logic       v5, rdy5, mode5, ov5, ordy5, none5;
  logic [4:0] req5, oh5;
  logic [2:0] idx5;

  prio_encoder_rr #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_req(req8),
    .mode_rr(mode8), .out_valid(ov8), .out_ready(ordy8), .out_idx(idx8),
    .out_onehot(oh8), .out_none(none8)
  );

  prio_encoder_rr #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(rdy5), .in_req(req5),
    .mode_rr(mode5), .out_valid(ov5), .out_ready(ordy5), .out_idx(idx5),
    .out_onehot(oh5), .out_none(none5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int nn[2] = '{8, 5};
  int a_rst;
  int a_valid[2], a_req[2], a_mode[2], a_oready[2];
  int m_valid[2], m_idx[2], m_none[2], m_oh[2], m_ptr[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Winner = first requesting source met when walking the ring from start.
  function automatic int ring_search(int req, int start, int n);
    for (int k = 0; k < n; k++) begin
      if (((req >> ((start + k) % n)) & 1) != 0) return (start + k) % n;
    end
    return -1;
  endfunction

  function automatic void model_edge(int d);
    int g;
    bit rdy;
    rdy = (m_valid[d] == 0) || (a_oready[d] != 0);
    if (a_rst == 0) begin
      m_valid[d] = 0; m_idx[d] = 0; m_none[d] = 0; m_oh[d] = 0; m_ptr[d] = 0;
    end else if (a_valid[d] != 0 && rdy) begin
      g = ring_search(a_req[d], (a_mode[d] != 0) ? m_ptr[d] : 0, nn[d]);
      m_valid[d] = 1;
      if (g < 0) begin
        m_none[d] = 1; m_idx[d] = 0; m_oh[d] = 0;
      end else begin
        m_none[d] = 0; m_idx[d] = g; m_oh[d] = 1 << g;
        if (a_mode[d] != 0) m_ptr[d] = (g + 1) % nn[d];
      end
    end else if (a_oready[d] != 0) begin
      m_valid[d] = 0;
    end
  endfunction

  // Starts and ends 1 time unit after a rising edge.
  task automatic step();
    rst_n = (a_rst != 0);
    v8 = (a_valid[0] != 0); req8 = 8'(a_req[0]); mode8 = (a_mode[0] != 0); ordy8 = (a_oready[0] != 0);
    v5 = (a_valid[1] != 0); req5 = 5'(a_req[1]); mode5 = (a_mode[1] != 0); ordy5 = (a_oready[1] != 0);
    #1;
    check("in_ready8", 32'(rdy8), 32'((m_valid[0] == 0) || (a_oready[0] != 0)));
    check("in_ready5", 32'(rdy5), 32'((m_valid[1] == 0) || (a_oready[1] != 0)));
    @(posedge clk);
    #1;
    model_edge(0);
    model_edge(1);
    check("out_valid8", 32'(ov8), 32'(m_valid[0]));
    check("out_valid5", 32'(ov5), 32'(m_valid[1]));
    if (m_valid[0] != 0) begin
      check("out_idx8", 32'(idx8), 32'(m_idx[0]));
      check("out_onehot8", 32'(oh8), 32'(m_oh[0]));
      check("out_none8", 32'(none8), 32'(m_none[0]));
    end
    if (m_valid[1] != 0) begin
      check("out_idx5", 32'(idx5), 32'(m_idx[1]));
      check("out_onehot5", 32'(oh5), 32'(m_oh[1]));
      check("out_none5", 32'(none5), 32'(m_none[1]));
    end
  endtask

  task automatic drive8(int valid, int req, int mode, int oready);
    a_valid[0] = valid; a_req[0] = req; a_mode[0] = mode; a_oready[0] = oready;
    step();
  endtask

  initial begin
    a_rst = 0;
    for (int d = 0; d < 2; d++) begin
      a_valid[d] = 0; a_req[d] = 0; a_mode[d] = 0; a_oready[d] = 1;
      m_valid[d] = 0; m_idx[d] = 0; m_none[d] = 0; m_oh[d] = 0; m_ptr[d] = 0;
    end
    @(posedge clk);
    #1;
    step();
    step();
    check("rst_valid8", 32'(ov8), 32'd0);
    check("rst_idx8", 32'(idx8), 32'd0);
    check("rst_onehot8", 32'(oh8), 32'd0);
    check("rst_none8", 32'(none8), 32'd0);
    check("rst_valid5", 32'(ov5), 32'd0);
    a_rst = 1;

    drive8(1, 8'b1010_0100, 0, 1);
    check("fixed_idx", 32'(idx8), 32'd2);
    check("fixed_onehot", 32'(oh8), 32'h04);

    for (int k = 0; k < 10; k++) begin
      drive8(1, 8'hFF, 1, 1);
      check("rr_seq", 32'(idx8), 32'(k % 8));
    end

    drive8(1, 8'b0010_0000, 1, 1);
    check("rr_grant5", 32'(idx8), 32'd5);
    drive8(1, 8'b0000_0011, 1, 1);
    check("rr_wrap", 32'(idx8), 32'd0);
    drive8(1, 8'b0100_0001, 1, 1);
    check("rr_after_wrap", 32'(idx8), 32'd6);

    drive8(1, 8'h00, 0, 1);
    check("zero_fixed_none", 32'(none8), 32'd1);
    drive8(1, 8'h00, 1, 1);
    check("zero_rr_none", 32'(none8), 32'd1);
    check("zero_rr_onehot", 32'(oh8), 32'd0);
    drive8(1, 8'hFF, 1, 1);
    check("zero_keeps_ptr", 32'(idx8), 32'd7);

    drive8(1, 8'b0000_1000, 0, 1);
    check("bp_first", 32'(idx8), 32'd3);
    for (int k = 0; k < 3; k++) begin
      drive8(1, 8'b0000_0001, 0, 0);
      check("bp_ready_low", 32'(rdy8), 32'd0);
      check("bp_held_idx", 32'(idx8), 32'd3);
    end
    drive8(1, 8'b0000_0001, 0, 1);
    check("b2b_a", 32'(idx8), 32'd0);
    drive8(1, 8'b0000_0010, 0, 1);
    check("b2b_b_valid", 32'(ov8), 32'd1);
    check("b2b_b", 32'(idx8), 32'd1);
    drive8(0, 0, 0, 1);

    a_valid[1] = 1; a_req[1] = 5'b10000; a_mode[1] = 1; a_oready[1] = 0;
    step();
    check("n5_idx4", 32'(idx5), 32'd4);
    a_req[1] = 5'b00001;
    step();
    check("n5_stalled", 32'(idx5), 32'd4);
    a_rst = 0;
    step();
    check("n5_rst_valid", 32'(ov5), 32'd0);
    a_rst = 1; a_req[1] = 5'b10001; a_oready[1] = 1;
    step();
    check("n5_after_rst", 32'(idx5), 32'd0);

    for (int c = 0; c < 400; c++) begin
      a_rst = ($urandom_range(0, 99) != 0) ? 1 : 0;
      for (int d = 0; d < 2; d++) begin
        a_valid[d]  = ($urandom_range(0, 3) != 0) ? 1 : 0;
        a_oready[d] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        a_mode[d]   = int'($urandom_range(0, 1));
        a_req[d]    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << nn[d]) - 1));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
